// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning front end.
// Debounce FSM states and board clock constants.
package btn_pkg;

    localparam int CLK_HZ        = 125_000_000;
    localparam int DEBOUNCE_10MS = 1_250_000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce FSM and sample counter.
// Produces a clean level and a one-cycle pulse on each accepted press.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // cnt holds samples already seen, so the window closes on the last one
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   press_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_q <= PEND_HI;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                PEND_HI: begin
                    if (!s) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HI;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_q <= PEND_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PEND_LO: begin
                    if (s) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        level_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: independent debounce channel per button.
// btn_press feeds the sequence detector, one pulse per physical press.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_ch (
            .clk  (clk),
            .clr_n(clr_n),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing,
// checked against a sample-window reference model.
module tb_button_conditioner;

    localparam int NB   = 4;
    localparam int DEB  = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;

    int n_checks = 0;
    int n_errs   = 0;

    button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a channel flips when its last DEB synchronised samples all
    // disagree with its current level; a 0->1 flip is a press.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_lvl = '0;
    logic [NB-1:0] m_prs = '0;

    always @(posedge clk or negedge clr_n) begin
        int  idx;
        logic v;
        logic all_opp;
        if (!clr_n) begin
            hist.delete();
            m_lvl = '0;
            m_prs = '0;
        end else begin
            hist.push_back(btn_raw);
            m_prs = '0;
            for (int b = 0; b < NB; b++) begin
                all_opp = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    idx = hist.size() - 1 - SYNC - j;
                    v   = (idx >= 0) ? hist[idx][b] : 1'b0;
                    if (v == m_lvl[b]) all_opp = 1'b0;
                end
                if (all_opp) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_prs[b] = m_lvl[b];
                end
            end
        end
    end

    always @(negedge clk) begin
        check_eq("level", 32'(btn_level), 32'(m_lvl));
        check_eq("press", 32'(btn_press), 32'(m_prs));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect pulse pattern exp exactly at the 10th edge after the last drive.
    task automatic expect_pulse(input string tag, input logic [NB-1:0] exp);
        cyc(SYNC + DEB - 1);
        check_eq({tag, "_early"}, 32'(btn_press), 32'(0));
        cyc(1);
        check_eq(tag, 32'(btn_press), 32'(exp));
        cyc(1);
        check_eq({tag, "_once"}, 32'(btn_press), 32'(0));
    endtask

    initial begin
        logic v3;
        // 1: buttons held through reset
        btn_raw = 4'hF;
        cyc(3);
        check_eq("rst_level", 32'(btn_level), 32'(0));
        check_eq("rst_press", 32'(btn_press), 32'(0));
        clr_n = 1'b1;
        expect_pulse("rst_held", 4'hF);
        btn_raw = '0;
        cyc(20);

        // 2: clean single press
        btn_raw[2] = 1'b1;
        expect_pulse("clean", 4'h4);
        cyc(50);
        check_eq("clean_level", 32'(btn_level), 32'(4'h4));
        btn_raw = '0;
        cyc(20);
        check_eq("release_level", 32'(btn_level), 32'(0));

        // 3: bouncing then settle high
        v3 = 1'b1;
        for (int p = 0; p < 14; p++) begin
            btn_raw[3] = v3;
            for (int k = 0; k < 3; k++) begin
                cyc(1);
                check_eq("bounce_quiet", 32'(btn_press), 32'(0));
            end
            v3 = ~v3;
        end
        btn_raw[3] = 1'b1;
        expect_pulse("bounce", 4'h8);
        btn_raw = '0;
        cyc(20);

        // 4: single-cycle glitch inside the window
        btn_raw[1] = 1'b1;
        cyc(7);
        btn_raw[1] = 1'b0;
        cyc(1);
        btn_raw[1] = 1'b1;
        expect_pulse("glitch", 4'h2);
        btn_raw = '0;
        cyc(20);

        // 5: simultaneous presses
        btn_raw = 4'h5;
        expect_pulse("simul", 4'h5);
        cyc(5);

        // 6: async reset mid-window while another level is high
        btn_raw[2] = 1'b0;
        cyc(20);
        btn_raw[2] = 1'b1;
        cyc(5);
        check_eq("pre_clr_level", 32'(btn_level), 32'(4'h1));
        #2 clr_n = 1'b0;
        #1;
        check_eq("clr_level", 32'(btn_level), 32'(0));
        check_eq("clr_press", 32'(btn_press), 32'(0));
        @(negedge clk);
        clr_n = 1'b1;
        cyc(4);
        check_eq("orig_expiry", 32'(btn_press), 32'(0));
        cyc(5);
        check_eq("post_clr_early", 32'(btn_press), 32'(0));
        cyc(1);
        check_eq("post_clr", 32'(btn_press), 32'(4'h5));
        btn_raw = '0;
        cyc(20);

        // Random bouncing with occasional async resets
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 11) == 0) btn_raw[b] = ~btn_raw[b];
            if ($urandom_range(0, 499) == 0) begin
                #($urandom_range(1, 8)) clr_n = 1'b0;
                @(negedge clk);
                clr_n = 1'b1;
            end else begin
                cyc(1);
            end
        end
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_errs);
        $finish;
    end

endmodule
